axi_burst_master: RTL and testbench

- Parametrised successor to the single-beat CPU-side AXI master: it bridges one CPU-side memory port (L1 cache refill/store path) onto one AXI4 master port.
- Reads are INCR bursts of 1..2^LEN_W beats, so a full cache line is fetched in one transaction.
- Writes are single-beat with byte strobes.
- Reports per-beat read data, a completion pulse and a response-error flag.
- One instance per CPU master port (M0 instruction refill, M1 data).

---
 rtl/axi_burst_pkg.sv | 20 ++
 rtl/axi_burst_master.sv | 261 ++++++++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_pkg.sv
// Shared AXI encodings and FSM state type for the CPU-side burst master.
package axi_burst_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    AW_W = 3'd3,
    B    = 3'd4
  } state_t;

  // AXI AxSIZE encoding for a full-width beat of data_w bits.
  function automatic logic [2:0] axi_size(input int unsigned data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/axi_burst_master.sv
// CPU-side memory port to AXI4 master bridge: INCR read bursts of
// 1..2^LEN_W beats, single-beat strobed writes, one transaction in flight.
module axi_burst_master
  import axi_burst_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter int              ID_W      = 4,
  parameter int              LEN_W     = 4,
  parameter logic [ID_W-1:0] MASTER_ID = {ID_W{1'b0}}
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  // core side
  input  logic                core_req,
  input  logic                core_we,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [LEN_W-1:0]    core_len,
  input  logic [DATA_W/8-1:0] core_wstrb,
  input  logic [DATA_W-1:0]   core_wdata,
  output logic [DATA_W-1:0]   core_rdata,
  output logic                core_rvalid,
  output logic                core_done,
  output logic                core_err,
  output logic                core_stall,
  // read address channel
  output logic [ID_W-1:0]     ARID,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [7:0]          ARLEN,
  output logic [2:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  output logic                ARVALID,
  input  logic                ARREADY,
  // read data channel
  input  logic [ID_W-1:0]     RID,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY,
  // write address channel
  output logic [ID_W-1:0]     AWID,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [7:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                AWVALID,
  input  logic                AWREADY,
  // write data channel
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  // write response channel
  input  logic [ID_W-1:0]     BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY
);

  localparam int         STRB_W = DATA_W / 8;
  localparam logic [2:0] SIZE_C = axi_size(DATA_W);

  state_t state_r, next_state_s;

  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W-1:0]  len_r;
  logic [STRB_W-1:0] wstrb_r;
  logic [DATA_W-1:0] wdata_r;
  logic [LEN_W:0]    beats_r;
  logic              err_acc_r;
  logic              aw_done_r;
  logic              w_done_r;
  logic [DATA_W-1:0] rdata_r;
  logic              rvalid_r;
  logic              done_r;
  logic              err_r;

  logic accept_s;
  logic r_hs_s;
  logic aw_hs_s;
  logic w_hs_s;
  logic b_hs_s;
  logic aw_fin_s;
  logic w_fin_s;
  logic rresp_bad_s;
  logic len_mismatch_s;
  logic unused_s;

  // IDs are not checked: only one transaction is ever outstanding.
  assign unused_s = ^{RID, BID, 1'b0};

  // No new request is taken in the completion cycle, so a core that keeps
  // core_req high through core_done is not accepted twice.
  assign accept_s       = (state_r == IDLE) & core_req & ~done_r;
  assign r_hs_s         = (state_r == R) & RVALID;
  assign aw_hs_s        = (state_r == AW_W) & ~aw_done_r & AWREADY;
  assign w_hs_s         = (state_r == AW_W) & ~w_done_r & WREADY;
  assign b_hs_s         = (state_r == B) & BVALID;
  assign aw_fin_s       = aw_done_r | aw_hs_s;
  assign w_fin_s        = w_done_r | w_hs_s;
  assign rresp_bad_s    = (RRESP != AXI_RESP_OKAY);
  // beats_r counts beats before the current one, so the last beat is
  // correct exactly when beats_r equals len.
  assign len_mismatch_s = (beats_r != {1'b0, len_r});

  assign ARID    = MASTER_ID;
  assign ARADDR  = addr_r;
  assign ARLEN   = 8'(len_r);
  assign ARSIZE  = SIZE_C;
  assign ARBURST = AXI_BURST_INCR;
  assign AWID    = MASTER_ID;
  assign AWADDR  = addr_r;
  assign AWLEN   = 8'd0;
  assign AWSIZE  = SIZE_C;
  assign AWBURST = AXI_BURST_INCR;
  assign WDATA   = wdata_r;
  assign WSTRB   = wstrb_r;
  assign WLAST   = 1'b1;

  assign core_rdata  = rdata_r;
  assign core_rvalid = rvalid_r;
  assign core_done   = done_r;
  assign core_err    = err_r;
  assign core_stall  = ~done_r & (core_req | (state_r != IDLE));

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and channel VALID/READY decode from the current state.
  always_comb begin
    next_state_s = state_r;
    ARVALID      = 1'b0;
    RREADY       = 1'b0;
    AWVALID      = 1'b0;
    WVALID       = 1'b0;
    BREADY       = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (core_we) begin
            next_state_s = AW_W;
          end else begin
            next_state_s = AR;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      AR: begin
        ARVALID = 1'b1;
        if (ARREADY) begin
          next_state_s = R;
        end else begin
          next_state_s = AR;
        end
      end
      R: begin
        RREADY = 1'b1;
        if (RVALID && RLAST) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = R;
        end
      end
      AW_W: begin
        AWVALID = ~aw_done_r;
        WVALID  = ~w_done_r;
        if (aw_fin_s && w_fin_s) begin
          next_state_s = B;
        end else begin
          next_state_s = AW_W;
        end
      end
      B: begin
        BREADY = 1'b1;
        if (BVALID) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = B;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Request capture, beat/error bookkeeping and registered core outputs.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      addr_r    <= {ADDR_W{1'b0}};
      len_r     <= {LEN_W{1'b0}};
      wstrb_r   <= {STRB_W{1'b0}};
      wdata_r   <= {DATA_W{1'b0}};
      beats_r   <= {(LEN_W + 1){1'b0}};
      err_acc_r <= 1'b0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
      rdata_r   <= {DATA_W{1'b0}};
      rvalid_r  <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      rvalid_r <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            addr_r    <= core_addr;
            len_r     <= core_len;
            wstrb_r   <= core_wstrb;
            wdata_r   <= core_wdata;
            beats_r   <= {(LEN_W + 1){1'b0}};
            err_acc_r <= 1'b0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
          end
        end
        R: begin
          if (r_hs_s) begin
            rdata_r   <= RDATA;
            rvalid_r  <= 1'b1;
            beats_r   <= beats_r + (LEN_W + 1)'(1);
            err_acc_r <= err_acc_r | rresp_bad_s;
            if (RLAST) begin
              done_r <= 1'b1;
              err_r  <= err_acc_r | rresp_bad_s | len_mismatch_s;
            end
          end
        end
        AW_W: begin
          if (aw_hs_s) begin
            aw_done_r <= 1'b1;
          end
          if (w_hs_s) begin
            w_done_r <= 1'b1;
          end
        end
        B: begin
          if (b_hs_s) begin
            done_r <= 1'b1;
            err_r  <= (BRESP != AXI_RESP_OKAY);
          end
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed self-checking bench for axi_burst_master with a small AXI slave
// model and a scoreboard of expected read beats and completion errors.
module tb_axi_burst_master;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic [3:0]  core_len, core_wstrb;
  logic        core_rvalid, core_done, core_err, core_stall;
  logic [3:0]  ARID, RID, AWID, BID;
  logic [31:0] ARADDR, RDATA, AWADDR, WDATA;
  logic [7:0]  ARLEN, AWLEN;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic [3:0]  WSTRB;

  axi_burst_master dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_len(core_len),
    .core_wstrb(core_wstrb), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_rvalid(core_rvalid), .core_done(core_done), .core_err(core_err), .core_stall(core_stall),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  // Free-running clock, period 10.
  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  logic [31:0] rq[$];
  logic        dq[$];

  int          ar_delay, aw_delay, w_delay, n_beats;
  int          gaps[4];
  logic [1:0]  rresps[4];
  logic [31:0] rdat[4];
  logic [1:0]  bresp;

  logic [31:0] exp_addr, exp_wdata;
  logic [7:0]  exp_len;
  logic [3:0]  exp_wstrb;

  int ar_cnt, aw_cnt, w_cnt, r_idx, r_gap;
  bit r_active, aw_seen, w_seen, b_pend;
  bit ar_hs_l, r_hs_l, aw_hs_l, w_hs_l, b_hs_l;
  int ar_hs_n, aw_hs_n, w_hs_n, b_hs_n;
  bit got_done;
  int lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_slave();
    ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RDATA = 32'd0; RRESP = 2'b00; RID = 4'd0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00; BID = 4'd0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_idx = 0; r_gap = 0;
    r_active = 1'b0; aw_seen = 1'b0; w_seen = 1'b0; b_pend = 1'b0;
    ar_hs_l = 1'b0; r_hs_l = 1'b0; aw_hs_l = 1'b0; w_hs_l = 1'b0; b_hs_l = 1'b0;
  endtask

  // Called at the falling edge: note the handshakes of the coming rising
  // edge and check the registered core outputs against the scoreboard.
  task automatic sample();
    ar_hs_l = ARVALID && ARREADY;
    r_hs_l  = RVALID && RREADY;
    aw_hs_l = AWVALID && AWREADY;
    w_hs_l  = WVALID && WREADY;
    b_hs_l  = BVALID && BREADY;
    if (core_rvalid) begin
      if (rq.size() == 0) chk("rvalid_unexpected", 64'd1, 64'd0);
      else chk("rdata", core_rdata, rq.pop_front());
    end
    if (core_done) begin
      got_done = 1'b1;
      if (dq.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
      else chk("core_err", core_err, dq.pop_front());
      chk("stall_in_done", core_stall, 64'd0);
    end
    if (ar_hs_l) begin
      ar_hs_n++;
      chk("araddr", ARADDR, exp_addr);
      chk("arlen", ARLEN, exp_len);
      chk("ar_id_size_burst", {ARID, ARSIZE, ARBURST}, {4'd0, 3'd2, 2'b01});
    end
    if (aw_hs_l) begin
      aw_hs_n++;
      chk("awaddr", AWADDR, exp_addr);
      chk("aw_id_len_size_burst", {AWID, AWLEN, AWSIZE, AWBURST}, {4'd0, 8'd0, 3'd2, 2'b01});
    end
    if (w_hs_l) begin
      w_hs_n++;
      chk("wdata", WDATA, exp_wdata);
      chk("wstrb_wlast", {WSTRB, WLAST}, {exp_wstrb, 1'b1});
    end
    if (b_hs_l) b_hs_n++;
  endtask

  // Called just after the rising edge: advance the slave model.
  task automatic drive();
    if (ARVALID) begin ARREADY = (ar_cnt >= ar_delay); ar_cnt++; end
    else begin ARREADY = 1'b0; ar_cnt = 0; end
    if (ar_hs_l) begin r_active = 1'b1; r_idx = 0; r_gap = 0; end
    if (r_hs_l) begin r_idx++; r_gap = 0; end
    if (r_active && r_idx < n_beats) begin
      if (r_gap >= gaps[r_idx]) begin
        RVALID = 1'b1; RDATA = rdat[r_idx]; RRESP = rresps[r_idx];
        RLAST = (r_idx == n_beats - 1);
      end else begin
        RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00; r_gap++;
      end
    end else begin
      r_active = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
    end
    if (AWVALID) begin AWREADY = (aw_cnt >= aw_delay); aw_cnt++; end
    else begin AWREADY = 1'b0; aw_cnt = 0; end
    if (WVALID) begin WREADY = (w_cnt >= w_delay); w_cnt++; end
    else begin WREADY = 1'b0; w_cnt = 0; end
    if (b_hs_l) b_pend = 1'b0;
    if (aw_hs_l) aw_seen = 1'b1;
    if (w_hs_l) w_seen = 1'b1;
    if (aw_seen && w_seen) begin b_pend = 1'b1; aw_seen = 1'b0; w_seen = 1'b0; end
    BVALID = b_pend;
    BRESP  = bresp;
  endtask

  task automatic begin_txn(input logic we, input logic [31:0] addr, input logic [3:0] len,
                           input logic [3:0] strb, input logic [31:0] wd);
    @(posedge ACLK); #1;
    core_req = 1'b1; core_we = we; core_addr = addr; core_len = len;
    core_wstrb = strb; core_wdata = wd;
    exp_addr = addr; exp_len = {4'd0, len}; exp_wstrb = strb; exp_wdata = wd;
    ar_hs_n = 0; aw_hs_n = 0; w_hs_n = 0; b_hs_n = 0;
    drive();
  endtask

  task automatic run_txn(input int budget, output int l);
    int cyc = 0;
    got_done = 1'b0;
    while (1) begin
      @(negedge ACLK);
      if (cyc == 0) begin
        chk("stall_on_req", core_stall, 64'd1);
        chk("no_valid_first_cycle", {ARVALID, AWVALID}, 64'd0);
      end
      sample();
      if (got_done || cyc >= budget) break;
      @(posedge ACLK); #1;
      drive();
      cyc++;
    end
    chk("done_seen", got_done, 64'd1);
    l = cyc;
  endtask

  task automatic end_txn();
    @(posedge ACLK); #1;
    core_req = 1'b0;
    drive();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] len,
                         input logic err_exp, input bit keep_req);
    int exp_lat = 3 + ar_delay + n_beats - 1;
    for (int i = 0; i < n_beats; i++) begin
      rq.push_back(rdat[i]);
      exp_lat += gaps[i];
    end
    dq.push_back(err_exp);
    begin_txn(1'b0, addr, len, 4'd0, 32'd0);
    run_txn(60, lat);
    chk("read_latency", lat, exp_lat);
    chk("ar_count", ar_hs_n, 64'd1);
    chk("all_beats_seen", rq.size(), 64'd0);
    if (!keep_req) end_txn();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] wd, input logic err_exp);
    int m = (aw_delay > w_delay) ? aw_delay : w_delay;
    dq.push_back(err_exp);
    begin_txn(1'b1, addr, 4'd0, strb, wd);
    run_txn(60, lat);
    chk("write_latency", lat, 3 + m);
    chk("aw_w_b_counts", {aw_hs_n[7:0], w_hs_n[7:0], b_hs_n[7:0]}, {8'd1, 8'd1, 8'd1});
    end_txn();
  endtask

  task automatic set_read(input int ard, input int nb, input int g0, input int g1,
                          input int g2, input int g3, input logic [31:0] base);
    ar_delay = ard; n_beats = nb;
    gaps[0] = g0; gaps[1] = g1; gaps[2] = g2; gaps[3] = g3;
    for (int i = 0; i < 4; i++) begin
      rresps[i] = 2'b00;
      rdat[i] = base + 32'(i) * 32'h0101_0101;
    end
  endtask

  initial begin
    ARESETn = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = 32'd0; core_len = 4'd0;
    core_wstrb = 4'd0; core_wdata = 32'd0;
    ar_delay = 0; aw_delay = 0; w_delay = 0; n_beats = 1; bresp = 2'b00;
    set_read(0, 1, 0, 0, 0, 0, 32'd0);
    reset_slave();

    // Reset state
    #12;
    chk("reset_valids", {ARVALID, RREADY, AWVALID, WVALID, BREADY}, 64'd0);
    chk("reset_core_out", {core_rvalid, core_done, core_err, core_stall}, 64'd0);
    chk("reset_rdata", core_rdata, 64'd0);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;

    // Single-beat read, ARREADY after two wait cycles
    set_read(2, 1, 0, 0, 0, 0, 32'hDEAD_BEEF);
    do_read(32'h0001_0040, 4'd0, 1'b0, 1'b0);

    // Four-beat line refill with RVALID gaps 0/2/0/1
    set_read(0, 4, 0, 2, 0, 1, 32'hA000_0010);
    do_read(32'h0000_0100, 4'd3, 1'b0, 1'b0);

    // Write with W accepted three cycles before AW
    aw_delay = 3; w_delay = 0; bresp = 2'b00;
    do_write(32'h0000_0200, 4'b0011, 32'h1234_5678, 1'b0);

    // Write with AW and W accepted in the same cycle
    aw_delay = 0; w_delay = 0;
    do_write(32'h0000_0204, 4'b1100, 32'hCAFE_F00D, 1'b0);

    // SLVERR on beat 2 of 4
    set_read(1, 4, 0, 0, 1, 0, 32'h5000_0000);
    rresps[1] = 2'b10;
    do_read(32'h0000_0400, 4'd3, 1'b1, 1'b0);

    // Slave ends the burst after 2 beats although 4 were asked for
    set_read(0, 2, 0, 0, 0, 0, 32'h6000_0000);
    do_read(32'h0000_0480, 4'd3, 1'b1, 1'b0);

    // All-zero strobe write still issued; DECERR reported
    aw_delay = 1; w_delay = 2; bresp = 2'b11;
    do_write(32'h0000_0208, 4'b0000, 32'h0BAD_CAFE, 1'b1);
    bresp = 2'b00;

    // Reset while the second read beat is being offered
    set_read(0, 4, 0, 0, 0, 0, 32'h7000_0000);
    for (int i = 0; i < 4; i++) rq.push_back(rdat[i]);
    dq.push_back(1'b0);
    begin_txn(1'b0, 32'h0000_0300, 4'd3, 4'd0, 32'd0);
    for (int c = 0; c < 20; c++) begin
      @(negedge ACLK);
      sample();
      if (RVALID && RREADY && r_idx == 1) break;
      @(posedge ACLK); #1;
      drive();
    end
    chk("reached_beat1", {RVALID, RREADY, r_idx[3:0]}, {1'b1, 1'b1, 4'd1});
    ARESETn = 1'b0;
    #1;
    chk("async_reset_valids", {ARVALID, RREADY, AWVALID, WVALID, BREADY}, 64'd0);
    chk("async_reset_core", {core_rvalid, core_done, core_err}, 64'd0);
    chk("async_reset_rdata", core_rdata, 64'd0);
    core_req = 1'b0;
    #1;
    chk("stall_after_reset", core_stall, 64'd0);
    rq.delete();
    dq.delete();
    reset_slave();
    @(posedge ACLK); @(posedge ACLK); #1;
    ARESETn = 1'b1;
    set_read(0, 2, 0, 1, 0, 0, 32'h7100_0000);
    do_read(32'h0000_0340, 4'd1, 1'b0, 1'b0);

    // Back-to-back: core_req stays high through done, next read follows
    set_read(0, 1, 0, 0, 0, 0, 32'h8000_0001);
    do_read(32'h0000_0500, 4'd0, 1'b0, 1'b1);
    set_read(0, 2, 0, 0, 0, 0, 32'h8100_0002);
    do_read(32'h0000_0540, 4'd1, 1'b0, 1'b0);

    @(negedge ACLK);
    chk("idle_at_end", {core_stall, ARVALID, AWVALID, RREADY, BREADY}, 64'd0);
    chk("scoreboard_empty", rq.size() + dq.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
